// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch/branch logic.
package mips_pkg;

    localparam int unsigned PC_INC       = 4;
    localparam int unsigned IMM_W        = 16;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
//   clk, rst_n : clock, async active-low reset (clears to 0)
//   inc        : count request for this cycle
//   q          : registered count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    // Next count: hold once all-ones is reached so the value never wraps.
    always_comb begin
        q_d = q;
        if (inc && (q != {W{1'b1}})) begin
            q_d = q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule : sat_counter

// File: rtl/branch_pc_ctrl.sv
// Fetch-stage PC generator and branch-recovery controller.
// Steers fetch from the IF-stage prediction, tracks the predicted branch
// into ID, and redirects/flushes when ID resolution or a jump disagrees.
//   clk, rst_n     : clock, async active-low reset
//   stall          : freezes PC and the pending branch record
//   branch_if      : IF instruction is a beq; imm_if is its offset
//   branch_or_not  : predictor says taken for the IF branch
//   branch_id      : beq in ID resolves; equal_or_not is its outcome
//   jump/jump_addr : unconditional redirect from ID
//   pc             : registered fetch address
//   flush_if       : combinational, kill the IF/ID instruction
//   mispredict     : combinational, resolution disagreed with prediction
//   br_cnt/mp_cnt  : saturating resolved-branch / mispredict counts
//   err            : sticky, resolution seen with no pending record
module branch_pc_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned              ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]        RESET_PC = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned              CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_if,
    input  logic [IMM_W-1:0]  imm_if,
    input  logic              branch_or_not,
    input  logic              branch_id,
    input  logic              equal_or_not,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic              flush_if,
    output logic              mispredict,
    output logic [CNT_W-1:0]  br_cnt,
    output logic [CNT_W-1:0]  mp_cnt,
    output logic              err
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_v_q, pend_v_d;
    logic              pend_tk_q, pend_tk_d;
    logic [ADDR_W-1:0] pend_alt_q, pend_alt_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] seq_c, tgt_c, imm_ext_c;
    logic              res_c, mp_c, jmp_c, redir_c;

    // Next-state logic: targets, resolution, next PC and pending record.
    always_comb begin
        seq_c      = pc_q + ADDR_W'(PC_INC);
        imm_ext_c  = {{(ADDR_W - IMM_W){imm_if[IMM_W-1]}}, imm_if};
        tgt_c      = seq_c + (imm_ext_c << 2);

        // Gating with rst_n keeps the combinational outputs quiet in reset.
        res_c      = branch_id & ~stall & rst_n;
        mp_c       = res_c & pend_v_q & (equal_or_not != pend_tk_q);
        jmp_c      = jump & ~stall & rst_n;
        redir_c    = mp_c | jmp_c;

        pc_d       = seq_c;
        pend_v_d   = pend_v_q;
        pend_tk_d  = pend_tk_q;
        pend_alt_d = pend_alt_q;
        err_d      = err_q | (res_c & ~pend_v_q);

        // Mispredict outranks a coincident jump.
        if (mp_c) begin
            pc_d = pend_alt_q;
        end else if (jmp_c) begin
            pc_d = jump_addr;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (branch_if && branch_or_not) begin
            pc_d = tgt_c;
        end

        // The IF instruction is wrong-path on a redirect, so drop its record.
        if (redir_c) begin
            pend_v_d = 1'b0;
        end else if (!stall) begin
            pend_v_d   = branch_if;
            pend_tk_d  = branch_or_not;
            pend_alt_d = branch_or_not ? seq_c : tgt_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            pend_v_q   <= 1'b0;
            pend_tk_q  <= 1'b0;
            pend_alt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_v_q   <= pend_v_d;
            pend_tk_q  <= pend_tk_d;
            pend_alt_q <= pend_alt_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (res_c),
        .q     (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (mp_c),
        .q     (mp_cnt)
    );

    assign pc         = pc_q;
    assign err        = err_q;
    assign flush_if   = redir_c;
    assign mispredict = mp_c;

endmodule : branch_pc_ctrl

// File: tb/tb_branch_pc_ctrl.sv
// Randomized and directed bench for branch_pc_ctrl against a behavioural model.
module tb_branch_pc_ctrl;

    localparam int unsigned AW   = 32;
    localparam int unsigned CW   = 4;
    localparam logic [31:0] RPC  = 32'h0000_0100;
    localparam int          CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          stall;
    logic          branch_if;
    logic [15:0]   imm_if;
    logic          branch_or_not;
    logic          branch_id;
    logic          equal_or_not;
    logic          jump;
    logic [AW-1:0] jump_addr;
    logic [AW-1:0] pc;
    logic          flush_if;
    logic          mispredict;
    logic [CW-1:0] br_cnt;
    logic [CW-1:0] mp_cnt;
    logic          err;

    int n_checks;
    int n_errors;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_alt;
    bit          m_pv;
    bit          m_tk;
    bit          m_err;
    int          m_br;
    int          m_mp;

    branch_pc_ctrl #(
        .ADDR_W   (AW),
        .RESET_PC (RPC),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_if     (branch_if),
        .imm_if        (imm_if),
        .branch_or_not (branch_or_not),
        .branch_id     (branch_id),
        .equal_or_not  (equal_or_not),
        .jump          (jump),
        .jump_addr     (jump_addr),
        .pc            (pc),
        .flush_if      (flush_if),
        .mispredict    (mispredict),
        .br_cnt        (br_cnt),
        .mp_cnt        (mp_cnt),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc  = RPC;
        m_alt = '0;
        m_pv  = 1'b0;
        m_tk  = 1'b0;
        m_err = 1'b0;
        m_br  = 0;
        m_mp  = 0;
    endtask

    task automatic drive(input bit st, input bit bi, input logic [15:0] imm, input bit bon,
                         input bit bid, input bit eq, input bit jp, input logic [31:0] ja);
        stall         = st;
        branch_if     = bi;
        imm_if        = imm;
        branch_or_not = bon;
        branch_id     = bid;
        equal_or_not  = eq;
        jump          = jp;
        jump_addr     = ja;
    endtask

    // One clock with inputs already applied just after a falling edge.
    task automatic cycle();
        logic [31:0] seq, tgt, nxt;
        int          off;
        bit          res, mp, jmp;
        #1;
        off = int'($signed(imm_if)) * 4;
        seq = m_pc + 32'd4;
        tgt = m_pc + 32'd4 + 32'(off);
        res = branch_id && !stall;
        mp  = res && m_pv && (equal_or_not != m_tk);
        jmp = jump && !stall;
        chk("mispredict", 64'(mispredict), 64'(mp));
        chk("flush_if", 64'(flush_if), 64'(mp || jmp));

        if (mp)                              nxt = m_alt;
        else if (jmp)                        nxt = jump_addr;
        else if (stall)                      nxt = m_pc;
        else if (branch_if && branch_or_not) nxt = tgt;
        else                                 nxt = seq;

        if (res) begin
            if (!m_pv) m_err = 1'b1;
            if (m_br < CMAX) m_br++;
        end
        if (mp && m_mp < CMAX) m_mp++;

        if (mp || jmp) begin
            m_pv = 1'b0;
        end else if (!stall) begin
            m_pv  = branch_if;
            m_tk  = branch_or_not;
            m_alt = branch_or_not ? seq : tgt;
        end
        m_pc = nxt;

        @(posedge clk);
        #1;
        chk("pc", 64'(pc), 64'(m_pc));
        chk("br_cnt", 64'(br_cnt), 64'(m_br));
        chk("mp_cnt", 64'(mp_cnt), 64'(m_mp));
        chk("err", 64'(err), 64'(m_err));
        @(negedge clk);
    endtask

    // Asynchronous reset applied mid-cycle; state must clear immediately.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_pc", 64'(pc), 64'(RPC));
        chk("rst_flush", 64'(flush_if), 64'(0));
        chk("rst_mispredict", 64'(mispredict), 64'(0));
        chk("rst_br_cnt", 64'(br_cnt), 64'(0));
        chk("rst_mp_cnt", 64'(mp_cnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 16'h0, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b1;
        // A jump held during reset must not leak onto flush_if.
        drive(0, 0, 16'h0, 0, 1, 1, 1, 32'h999);
        model_reset();
        @(negedge clk);
        do_reset();

        // Sequential fetch from the reset PC.
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 16'h0, 0, 0, 0, 0, 32'h0);
            cycle();
        end
        chk("seq_pc", 64'(pc), 64'h10C);

        // Predicted taken, resolved taken.
        drive(0, 0, 16'h0, 0, 0, 0, 1, 32'h200); cycle();
        drive(0, 1, 16'h0004, 1, 0, 0, 0, 32'h0); cycle();
        chk("tk_pc", 64'(pc), 64'h214);
        drive(0, 0, 16'h0, 0, 1, 1, 0, 32'h0); cycle();
        chk("tk_br_cnt", 64'(br_cnt), 64'd1);

        // Predicted taken, resolved not taken.
        drive(0, 0, 16'h0, 0, 0, 0, 1, 32'h200); cycle();
        drive(0, 1, 16'h0004, 1, 0, 0, 0, 32'h0); cycle();
        drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0); cycle();
        chk("mp_pc", 64'(pc), 64'h204);
        chk("mp_cnt1", 64'(mp_cnt), 64'd1);

        // Predicted not taken with negative offset, resolved taken.
        drive(0, 0, 16'h0, 0, 0, 0, 1, 32'h300); cycle();
        drive(0, 1, 16'hFFFF, 0, 0, 0, 0, 32'h0); cycle();
        chk("nt_pc", 64'(pc), 64'h304);
        drive(0, 0, 16'h0, 0, 1, 1, 0, 32'h0); cycle();
        chk("neg_pc", 64'(pc), 64'h300);

        // Resolution under stall is deferred to the first unstalled cycle.
        drive(0, 0, 16'h0, 0, 0, 0, 1, 32'h400); cycle();
        drive(0, 1, 16'h0008, 1, 0, 0, 0, 32'h0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0, 0, 1, 0, 0, 32'h0); cycle();
        end
        chk("stall_pc", 64'(pc), 64'h424);
        drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0); cycle();
        chk("stall_res_pc", 64'(pc), 64'h404);

        // Resolution without a pending record sets sticky err.
        drive(0, 0, 16'h0, 0, 1, 1, 0, 32'h0); cycle();
        drive(0, 0, 16'h0, 0, 0, 0, 0, 32'h0); cycle();
        chk("err_sticky", 64'(err), 64'd1);

        // Mispredict counter saturation.
        for (int i = 0; i < 17; i++) begin
            drive(0, 1, 16'h0000, 1, 0, 0, 0, 32'h0); cycle();
            drive(0, 0, 16'h0, 0, 1, 0, 0, 32'h0); cycle();
        end
        chk("mp_sat", 64'(mp_cnt), 64'd15);
        chk("br_sat", 64'(br_cnt), 64'd15);

        // Mid-operation reset with a jump in flight.
        drive(0, 0, 16'h0, 0, 0, 0, 1, 32'h800);
        do_reset();

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(49) == 0) begin
                drive($urandom_range(1), $urandom_range(1), 16'($urandom), $urandom_range(1),
                      $urandom_range(1), $urandom_range(1), 1, $urandom & 32'hFFFF_FFFC);
                do_reset();
            end else begin
                drive($urandom_range(4) == 0,
                      $urandom_range(4) < 2,
                      16'($urandom),
                      $urandom_range(1),
                      m_pv ? ($urandom_range(3) != 0) : ($urandom_range(19) == 0),
                      $urandom_range(1),
                      $urandom_range(9) == 0,
                      $urandom & 32'hFFFF_FFFC);
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_branch_pc_ctrl
